// File: rtl/fp_pkg.sv
// Shared floating-point widths and the state type of the sequential mantissa divider.
package fp_pkg;

  localparam int FP32_MANT_W = 24;
  localparam int FP64_MANT_W = 53;
  localparam int FP32_EXP_W  = 8;
  localparam int FP64_EXP_W  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdiv_state_t;

endpackage

// File: rtl/cseladd.sv
// Carry-select adder: each block precomputes its sum for carry-in 0 and 1,
// and the incoming block carry picks one of them.
module cseladd #(
  parameter int N   = 25,
  parameter int BLK = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NB = (N + BLK - 1) / BLK;

  logic [NB:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
      // The last block absorbs whatever width is left over.
      localparam int LO = gi * BLK;
      localparam int BW = (gi == NB - 1) ? (N - LO) : BLK;

      logic [BW:0] s0;
      logic [BW:0] s1;

      assign s0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
      assign s1 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]} + (BW + 1)'(1);

      assign sum[LO +: BW] = carry[gi] ? s1[BW-1:0] : s0[BW-1:0];
      assign carry[gi+1]   = carry[gi] ? s1[BW] : s0[BW];
    end
  endgenerate

  assign cout = carry[NB];

endmodule

// File: rtl/mant_div_seq.sv
// Sequential restoring divider for normalized mantissas, one quotient bit per cycle.
// Define MANT_DIV_EARLY_TERM_EN to finish as soon as the partial remainder reaches zero.
import fp_pkg::*;

module mant_div_seq #(
  parameter int W  = FP32_MANT_W,
  parameter int QW = W + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic          sticky,
  output logic          dz
);

  localparam int CW = $clog2(QW);

  mdiv_state_t   state_q, state_d;
  logic [W:0]    r_q, r_d;
  logic [W-1:0]  b_q, b_d;
  logic [QW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic          dz_q, dz_d;

  logic [W:0]    diff;
  logic          ge;
  logic [W:0]    r_step;
  logic [QW-1:0] q_shift;

  // R - B as R + ~B + 1; the carry-out is set exactly when R >= B.
  cseladd #(.N(W + 1)) u_sub (
    .a    (r_q),
    .b    (~{1'b0, b_q}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (ge)
  );

  // R < 2B always holds, so the shifted remainder never overflows W+1 bits.
  assign r_step  = ge ? (diff << 1) : (r_q << 1);
  assign q_shift = {q_q[QW-2:0], ge};

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    b_d      = b_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d      = {1'b0, dividend};
          b_d      = divisor;
          q_d      = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          dz_d     = 1'b0;
          if (divisor == '0) begin
            dz_d    = 1'b1;
            q_d     = '1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        q_d   = q_shift;
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) begin
          state_d  = DONE;
          sticky_d = (r_step != '0);
        end
`ifdef MANT_DIV_EARLY_TERM_EN
        else if (r_step == '0) begin
          // Remaining quotient bits would all be zero: left-align now.
          q_d      = q_shift << (CW'(QW - 1) - cnt_q);
          state_d  = DONE;
          sticky_d = 1'b0;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      b_q      <= b_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = q_q;
  assign sticky    = sticky_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Scoreboard bench for mant_div_seq (W=24): a driver pushes expected results,
// an independent monitor pops and compares whenever out_valid rises.
module tb_mant_div_seq;

  localparam int W  = 24;
  localparam int QW = W + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic          sticky;
  logic          dz;

  mant_div_seq #(.W(W), .QW(QW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .sticky    (sticky),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [QW-1:0] q;
    logic          s;
    logic          dz;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  int   or_mode = 0;  // 0 random, 1 forced low, 2 forced high

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Quotient = floor(a * 2^(QW-1) / b); latency counted in edges after the accepting edge.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned num;
    e.a = a;
    e.b = b;
    e.acc = 0;
    if (b == '0) begin
      e.q = '1;
      e.s = 1'b0;
      e.dz = 1'b1;
      e.lat = 0;
      return e;
    end
    num = longint'(a) << (QW - 1);
    e.q = QW'(num / longint'(b));
    e.s = (num % longint'(b)) != 0;
    e.dz = 1'b0;
    e.lat = QW;
`ifdef MANT_DIV_EARLY_TERM_EN
    for (int k = 1; k <= QW; k++) begin
      if (((longint'(a) << (k - 1)) % longint'(b)) == 0) begin
        e.lat = k;
        break;
      end
    end
`endif
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [QW-1:0] q, input logic s, input bit use_tab);
    exp_t e;
    int g;
    e = model(a, b);
    if (use_tab) begin
      e.q = q;
      e.s = s;
    end
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    g = 0;
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare on the rising edge of out_valid, then check the result holds.
  initial begin
    bit   prev_valid;
    bit   prev_hs;
    exp_t cur;
    prev_valid = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        continue;
      end
      if (prev_hs) begin
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'(sb.size()), 64'd1);
          cur.q = quotient;
          cur.s = sticky;
          cur.dz = dz;
        end else begin
          cur = sb.pop_front();
          n_txn++;
          $display("txn %0d: %h / %h -> q=%h sticky=%b dz=%b lat=%0d (exp q=%h sticky=%b dz=%b lat=%0d)",
                   n_txn, cur.a, cur.b, quotient, sticky, dz, cyc - cur.acc,
                   cur.q, cur.s, cur.dz, cur.lat);
          check("quotient", 64'(quotient), 64'(cur.q));
          check("sticky", 64'(sticky), 64'(cur.s));
          check("dz", 64'(dz), 64'(cur.dz));
          check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end else if (out_valid) begin
        check("hold_quotient", 64'(quotient), 64'(cur.q));
        check("hold_sticky", 64'(sticky), 64'(cur.s));
        check("hold_dz", 64'(dz), 64'(cur.dz));
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      prev_hs = out_valid && out_ready;
      prev_valid = out_valid;
    end
  end

  initial begin
    int g;
    logic [W-1:0] ra, rb;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b1);
    send(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b1);
    send(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b1);
    send(24'h923456, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1);
    send(24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom) | 24'h800000;
      if ($urandom_range(0, 7) == 0) begin
        rb = '0;
      end else begin
        rb = (W'($urandom) & (W'($urandom_range(0, 2)) == 0 ? 24'h0000FF : 24'hFFFFFF))
             | 24'h800000;
      end
      send(ra, rb, '0, 1'b0, 1'b0);
    end
    drain();

    // Backpressure: result must hold for 10 cycles with out_ready low.
    or_mode = 1;
    @(posedge clk);
    send(24'hA00000, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1);
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    or_mode = 2;
    drain();
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    or_mode = 0;

    // Reset during the 12th busy cycle abandons the operation.
    send(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_quotient", 64'(quotient), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b1);
    send(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom) | 24'h800000, W'($urandom) | 24'h800000, '0, 1'b0, 1'b0);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mant_div_seq.md
MANT_DIV_SEQ -- requirements
Module: mant_div_seq

Interface
REQ-001 SHALL have parameter W, default 24, giving the normalized mantissa width including the hidden bit (24 for binary32, 53 for binary64).
REQ-002 SHALL have parameter QW, default W+2, giving the quotient width: 1 integer bit followed by W+1 fraction bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the dividend and divisor operands are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL have port dividend, input, W bits: mantissa of the numerator, {1, fraction}.
REQ-008 SHALL have port divisor, input, W bits: mantissa of the denominator, {1, fraction}.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage (exponent/normalize/round) accepts the result.
REQ-011 SHALL have port quotient, output, QW bits: the quotient, with the binary point after the MSB.
REQ-012 SHALL have port sticky, output, 1 bit: the final remainder is nonzero.
REQ-013 SHALL have port dz, output, 1 bit: divide by zero (divisor == 0).

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-015 SHALL, on an IDLE edge with in_valid high, latch R = {0, dividend} (W+1 bits) and B = divisor, clear the quotient and the bit counter, and go to BUSY.
REQ-016 SHALL, in each BUSY cycle, perform one restoring step: if R >= B then shift in quotient bit 1 and set R = (R-B)<<1, else shift in bit 0 and set R = R<<1, using W+1-bit arithmetic with no loss of the MSB.
REQ-017 SHALL go from BUSY to DONE on the edge that produces quotient bit QW, so that out_valid rises exactly QW edges after the accepting edge.
REQ-018 SHALL set sticky = (R != 0) once the last bit is computed.
REQ-019 SHALL, when divisor == 0 at acceptance, set dz = 1, quotient = all ones and sticky = 0, and go directly to DONE, so out_valid rises 1 edge after acceptance.
REQ-020 SHALL hold quotient, sticky and dz stable in DONE while out_ready is low (backpressure may last any length).
REQ-021 SHALL go from DONE to IDLE on an edge with out_ready high; it SHALL NOT accept a new operand in that same cycle, because in_ready is low in DONE.
REQ-022 SHALL ignore the dividend and divisor inputs outside IDLE; a change on them mid-operation SHALL have no effect.
REQ-023 SHALL treat a dividend or divisor whose MSB is 0 (other than the zero divisor) as undefined input, with no checking.

Reset
REQ-024 SHALL, while rst_n is low, immediately force state = IDLE, in_ready = 1 after reset, out_valid = 0, quotient = 0, sticky = 0, dz = 0, R = 0, B = 0 and counter = 0.
REQ-025 SHALL abandon any operation in progress when reset is asserted mid-operation, with no result emitted.

Configuration
REQ-026 SHALL use the macro MANT_DIV_EARLY_TERM_EN to enable early termination.
REQ-027 SHALL, when MANT_DIV_EARLY_TERM_EN is defined, left-align the quotient and zero-fill the remaining quotient bits once a BUSY step leaves R == 0, go to DONE on that edge with sticky = 0, and thus give variable latency of 1..QW edges.
REQ-028 SHALL, when MANT_DIV_EARLY_TERM_EN is undefined, have a fixed latency of QW edges, with a bit-identical quotient and sticky in both builds.

Structure
REQ-029 SHALL take from shared package fp_pkg the FP32/FP64 mantissa widths (24/53), the exponent widths and the state enum type mdiv_state_t {IDLE, BUSY, DONE}.
REQ-030 SHALL instantiate one sub-module, cseladd (W+1 bits, carry-in 1, with the operand inverted), to produce R-B; its carry-out is the R >= B decision.

Verification (W=24, QW=26)
REQ-031 SHALL cover: dividend 24'h800000, divisor 24'h800000 -> quotient 26'h2000000, sticky 0, dz 0, out_valid 26 edges after acceptance (1 edge with EARLY_TERM).
REQ-032 SHALL cover: dividend 24'hC00000, divisor 24'h800000 -> quotient 26'h3000000, sticky 0.
REQ-033 SHALL cover: dividend 24'h800000, divisor 24'hC00000 -> quotient 26'h1555555, sticky 1, latency 26 in both builds.
REQ-034 SHALL cover: divisor 0 -> dz 1, quotient 26'h3FFFFFF, out_valid 1 edge after acceptance.
REQ-035 SHALL cover: out_ready held low for 10 cycles in DONE -> outputs stable and in_ready 0; out_ready high -> IDLE next edge, and in_ready 1.
REQ-036 SHALL cover: rst_n pulsed low at BUSY cycle 12 -> out_valid 0 and in_ready 1 immediately; the next operation is correct.
